// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM state encoding and default datapath widths
// (also used by instruction_register).
package cpu_pkg;

  localparam int unsigned WORD_SIZE = 8;
  localparam int unsigned ADDR_SIZE = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LOAD  = 2'd2,
    EXEC  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_unit_pc_counter.sv
// Program counter: synchronous active-low reset to RESET_PC, increment or load,
// with load taking priority.
module pc_counter
  import cpu_pkg::*;
#(
  parameter int unsigned          addr_size = ADDR_SIZE,
  parameter logic [addr_size-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  input  logic                 load,
  input  logic [addr_size-1:0] load_val,
  output logic [addr_size-1:0] pc
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_val;
    end else if (inc) begin
      pc <= pc + 1'b1;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: req/ack fetch from program memory into the IR, PC ownership
// and branch redirect. Optional fetch timeout fault enabled by `define FETCH_TIMEOUT_EN.
module instruction_fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned          word_size      = WORD_SIZE,
  parameter int unsigned          addr_size      = ADDR_SIZE,
  parameter logic [addr_size-1:0] RESET_PC       = '0,
  parameter int unsigned          TIMEOUT_CYCLES = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fetch_en,
  output logic [addr_size-1:0] mem_addr,
  output logic                 mem_rd,
  input  logic [word_size-1:0] mem_data,
  input  logic                 mem_ack,
  output logic [word_size-1:0] ir_d_out,
  output logic                 ir_load,
  input  logic                 instr_done,
  input  logic                 branch_valid,
  input  logic [addr_size-1:0] branch_addr,
  output logic [addr_size-1:0] pc_out,
  output logic                 busy,
  output logic                 fault
);

  fetch_state_t         state, state_n;
  logic                 mem_rd_q, mem_rd_n;
  logic [word_size-1:0] ir_q, ir_n;
  logic                 ir_load_q, ir_load_n;
  logic                 pc_inc, pc_load;
  logic                 fetch_ok;
  logic [addr_size-1:0] pc;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             fault_q, fault_n;
`endif

  pc_counter #(
    .addr_size(addr_size),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk     (clk),
    .rst     (rst),
    .inc     (pc_inc),
    .load    (pc_load),
    .load_val(branch_addr),
    .pc      (pc)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      mem_rd_q  <= 1'b0;
      ir_q      <= '0;
      ir_load_q <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      cnt_q     <= '0;
      fault_q   <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      mem_rd_q  <= mem_rd_n;
      ir_q      <= ir_n;
      ir_load_q <= ir_load_n;
`ifdef FETCH_TIMEOUT_EN
      cnt_q     <= cnt_n;
      fault_q   <= fault_n;
`endif
    end
  end

  always_comb begin
    state_n   = state;
    mem_rd_n  = mem_rd_q;
    ir_n      = ir_q;
    ir_load_n = 1'b0;
    pc_inc    = 1'b0;
    pc_load   = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    cnt_n     = cnt_q;
    fault_n   = fault_q;
    fetch_ok  = fetch_en && !fault_q;
`else
    fetch_ok  = fetch_en;
`endif
    case (state)
      IDLE: begin
        if (fetch_ok) begin
          state_n  = FETCH;
          mem_rd_n = 1'b1;
`ifdef FETCH_TIMEOUT_EN
          cnt_n    = '0;
`endif
        end
      end
      FETCH: begin
        // An ack on the same edge as the timeout still completes the fetch.
        if (mem_ack) begin
          ir_n      = mem_data;
          pc_inc    = 1'b1;
          mem_rd_n  = 1'b0;
          ir_load_n = 1'b1;
          state_n   = LOAD;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          fault_n  = 1'b1;
          mem_rd_n = 1'b0;
          state_n  = IDLE;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
`endif
      end
      LOAD: begin
        state_n = EXEC;
      end
      EXEC: begin
        if (instr_done) begin
          pc_load = branch_valid;
          if (fetch_en) begin
            state_n  = FETCH;
            mem_rd_n = 1'b1;
`ifdef FETCH_TIMEOUT_EN
            cnt_n    = '0;
`endif
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign mem_addr = pc;
  assign pc_out   = pc;
  assign mem_rd   = mem_rd_q;
  assign ir_d_out = ir_q;
  assign ir_load  = ir_load_q;
  assign busy     = (state != IDLE);
`ifdef FETCH_TIMEOUT_EN
  assign fault    = fault_q;
`else
  assign fault    = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: randomized memory/decoder stimulus
// against a transaction-level PC/IR model.
module tb_instruction_fetch_unit;

  localparam int unsigned W = 8;
  localparam int unsigned A = 5;

  logic         clk = 1'b0;
  logic         rst, fetch_en, mem_rd, mem_ack, ir_load, instr_done, branch_valid, busy, fault;
  logic [A-1:0] mem_addr, branch_addr, pc_out;
  logic [W-1:0] mem_data, ir_d_out;

  always #5 clk = ~clk;

  instruction_fetch_unit #(
    .word_size     (W),
    .addr_size     (A),
    .RESET_PC      (5'd0),
    .TIMEOUT_CYCLES(15)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_en    (fetch_en),
    .mem_addr    (mem_addr),
    .mem_rd      (mem_rd),
    .mem_data    (mem_data),
    .mem_ack     (mem_ack),
    .ir_d_out    (ir_d_out),
    .ir_load     (ir_load),
    .instr_done  (instr_done),
    .branch_valid(branch_valid),
    .branch_addr (branch_addr),
    .pc_out      (pc_out),
    .busy        (busy),
    .fault       (fault)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: next fetch address, expected fetch addresses and IR contents
  typedef struct {
    logic [W-1:0] data;
    logic [A-1:0] next_pc;
  } ir_exp_t;

  logic [A-1:0] model_pc;
  logic [A-1:0] addr_q[$];
  ir_exp_t      ir_q[$];
  int unsigned  loads_seen = 0;
  int unsigned  loads_expected = 0;

  // Monitor: pops expectations whenever the DUT accepts a fetch or pulses ir_load
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (mem_rd && mem_ack) begin
        if (addr_q.size() == 0) check("unexpected_fetch_ack", mem_ack, 1'b0);
        else check("fetch_addr", 32'(mem_addr), 32'(addr_q.pop_front()));
      end
      if (ir_load) begin
        loads_seen++;
        if (ir_q.size() == 0) begin
          check("unexpected_ir_load", ir_load, 1'b0);
        end else begin
          ir_exp_t e;
          e = ir_q.pop_front();
          check("ir_d_out", 32'(ir_d_out), 32'(e.data));
          check("pc_after_fetch", 32'(pc_out), 32'(e.next_pc));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full fetch + decode. waits/data < 0 mean random.
  task automatic do_fetch(input int waits, input int data, input bit drop_en,
                          input bit force_br, input logic [A-1:0] br_addr, input bit stop_after);
    bit      seen;
    bit      br;
    ir_exp_t e;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mem_rd) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    if (!seen) begin
      check("mem_rd_wait", mem_rd, 1'b1);
      return;
    end
    if (drop_en) fetch_en = 1'b0;
    repeat ((waits < 0) ? $urandom_range(0, 3) : waits) tick();
    mem_ack  = 1'b1;
    mem_data = (data < 0) ? W'($urandom) : W'(data);
    addr_q.push_back(model_pc);
    model_pc  = model_pc + 1'b1;
    e.data    = mem_data;
    e.next_pc = model_pc;
    ir_q.push_back(e);
    loads_expected++;
    tick();
    mem_ack  = 1'b0;
    mem_data = W'($urandom);
    // instr_done during LOAD must be ignored
    if ($urandom_range(0, 3) == 0) begin
      instr_done   = 1'b1;
      branch_valid = 1'b1;
      branch_addr  = A'($urandom);
    end
    tick();
    instr_done   = 1'b0;
    branch_valid = 1'b0;
    check("busy_in_exec", busy, 1'b1);
    repeat ($urandom_range(0, 4)) begin
      case ($urandom_range(0, 2))
        0: begin branch_valid = 1'b1; branch_addr = A'($urandom); end
        1: mem_ack = 1'b1;
        default: ;
      endcase
      tick();
      branch_valid = 1'b0;
      mem_ack      = 1'b0;
    end
    check("pc_hold_exec", 32'(pc_out), 32'(model_pc));
    br           = force_br || ($urandom_range(0, 2) == 0);
    instr_done   = 1'b1;
    branch_valid = br;
    branch_addr  = force_br ? br_addr : A'($urandom);
    if (br) model_pc = branch_addr;
    if (stop_after) fetch_en = 1'b0;
    tick();
    instr_done   = 1'b0;
    branch_valid = 1'b0;
    if (!fetch_en) begin
      tick();
      check("idle_busy", busy, 1'b0);
      check("idle_mem_rd", mem_rd, 1'b0);
      check("idle_pc", 32'(pc_out), 32'(model_pc));
    end
  endtask

  task automatic check_reset_values();
    check("rst_pc_out", 32'(pc_out), 32'd0);
    check("rst_mem_rd", mem_rd, 1'b0);
    check("rst_ir_load", ir_load, 1'b0);
    check("rst_ir_d_out", 32'(ir_d_out), 32'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_fault", fault, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; fetch_en = 1'b0; mem_ack = 1'b0; mem_data = '0;
    instr_done = 1'b0; branch_valid = 1'b0; branch_addr = '0;
    model_pc = '0;
    tick();
    tick();
    check_reset_values();
    rst = 1'b1;
    tick();

    fetch_en = 1'b1;
    do_fetch(2, 8'hA5, 1'b0, 1'b0, '0, 1'b0);
    do_fetch(-1, -1, 1'b0, 1'b0, '0, 1'b0);
    do_fetch(-1, -1, 1'b0, 1'b0, '0, 1'b0);
    do_fetch(-1, -1, 1'b0, 1'b1, 5'd12, 1'b0);
    do_fetch(-1, -1, 1'b0, 1'b1, 5'd31, 1'b0);
    do_fetch(-1, -1, 1'b0, 1'b0, '0, 1'b0);
    do_fetch(-1, -1, 1'b1, 1'b0, '0, 1'b0);
    fetch_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      do_fetch(-1, -1, ($urandom_range(0, 7) == 0), 1'b0, '0, ($urandom_range(0, 7) == 0));
      fetch_en = 1'b1;
    end

    // Reset coinciding with an ack drops the fetch
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
        if (mem_rd) begin
          seen = 1'b1;
          break;
        end
        tick();
      end
      check("mem_rd_before_reset", mem_rd, 1'b1);
      mem_ack  = 1'b1;
      mem_data = 8'h3C;
      rst      = 1'b0;
      tick();
      mem_ack  = 1'b0;
      check("rst_no_ir_load", ir_load, 1'b0);
      tick();
      check_reset_values();
      model_pc = '0;
      rst = 1'b1;
    end
    do_fetch(-1, -1, 1'b0, 1'b0, '0, 1'b0);
    do_fetch(-1, -1, 1'b0, 1'b0, '0, 1'b1);

`ifdef FETCH_TIMEOUT_EN
    fetch_en = 1'b1;
    tick();
    repeat (14) tick();
    check("to_no_fault_yet", fault, 1'b0);
    check("to_mem_rd_held", mem_rd, 1'b1);
    tick();
    check("to_fault", fault, 1'b1);
    check("to_mem_rd_dropped", mem_rd, 1'b0);
    check("to_idle", busy, 1'b0);
    repeat (3) tick();
    check("to_fetch_en_ignored", busy, 1'b0);
    check("to_fault_sticky", fault, 1'b1);
    rst = 1'b0;
    fetch_en = 1'b0;
    tick();
    tick();
    check("to_fault_cleared", fault, 1'b0);
    rst = 1'b1;
`endif

    repeat (3) tick();
    check("ir_load_count", loads_seen, loads_expected);
    check("queues_drained", 32'(addr_q.size() + ir_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
